// File: rtl/melody_pkg.sv
// Shared types and constants for the melody sequencer: FSM state encoding and table entry layout.
package melody_pkg;

    localparam int NOTE_W = 6;
    localparam int DUR_W  = 10;

    localparam logic [NOTE_W-1:0] NOTE_REST = '0;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        PLAY,
        GAP,
        ADVANCE,
        DONE
    } seq_state_e;

    typedef struct packed {
        logic [NOTE_W-1:0] note;
        logic [DUR_W-1:0]  dur;
    } melody_entry_t;

endpackage

// File: rtl/melody_sequencer_tick_gen.sv
// Duration-tick prescaler: one-cycle tick every TICK_DIV clocks, restartable by a synchronous clear.
module tick_gen #(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    output logic tick_o
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear_i || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/melody_sequencer.sv
// Melody table player feeding the DAC SPI master with note code and note-enable.
// Define SEQ_LOOP_EN to replay the table continuously until stop instead of a single pass.
module melody_sequencer
    import melody_pkg::*;
#(
    parameter int TICK_DIV  = 100000,
    parameter int GAP_TICKS = 20,
    parameter int DEPTH     = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [6:0]        melody_len,
    input  logic              prog_we,
    input  logic [5:0]        prog_addr,
    input  logic [15:0]       prog_data,
    output logic [NOTE_W-1:0] note_state,
    output logic              button_action,
    output logic [5:0]        note_idx,
    output logic              busy,
    output logic              done
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    seq_state_e        state_q, state_d;
    logic [5:0]        idx_q, idx_d;
    logic [6:0]        len_q, len_d;
    logic [DUR_W-1:0]  dur_q, dur_d;
    logic [NOTE_W-1:0] note_state_q, note_state_d;
    logic              button_action_q;
    logic              busy_q;
    logic              done_q, done_d;

    melody_entry_t     mem_q [DEPTH];
    melody_entry_t     rd_q;
    logic [AW-1:0]     rd_addr;
    logic              we_ok;
    logic              is_last;
    logic              tick;
    logic              clr;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .rst     (rst),
        .clear_i (clr),
        .tick_o  (tick)
    );

    assign we_ok   = prog_we && (state_q == IDLE);
    assign rd_addr = idx_d[AW-1:0];
    assign is_last = ({1'b0, idx_q} == (len_q - 7'd1));

    // Write-first RAM: a write landing on the address being fetched is forwarded to the read register.
    always_ff @(posedge clk) begin
        if (we_ok) begin
            mem_q[prog_addr[AW-1:0]] <= melody_entry_t'(prog_data);
        end
        if (we_ok && (prog_addr[AW-1:0] == rd_addr)) begin
            rd_q <= melody_entry_t'(prog_data);
        end else begin
            rd_q <= mem_q[rd_addr];
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        len_d        = len_q;
        dur_d        = dur_q;
        note_state_d = note_state_q;
        done_d       = 1'b0;
        clr          = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    if (melody_len != 7'd0) begin
                        state_d = FETCH;
                        idx_d   = '0;
                        len_d   = melody_len;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            FETCH: begin
                if (rd_q.dur == '0) begin
                    state_d = ADVANCE;
                end else begin
                    state_d      = PLAY;
                    dur_d        = rd_q.dur;
                    note_state_d = rd_q.note;
                    clr          = 1'b1;
                end
            end
            PLAY: begin
                if (tick) begin
                    if (dur_q == DUR_W'(1)) begin
                        if (GAP_TICKS == 0) begin
                            state_d = ADVANCE;
                        end else begin
                            state_d = GAP;
                            dur_d   = DUR_W'(GAP_TICKS);
                            clr     = 1'b1;
                        end
                    end else begin
                        dur_d = dur_q - DUR_W'(1);
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    if (dur_q == DUR_W'(1)) begin
                        state_d = ADVANCE;
                    end else begin
                        dur_d = dur_q - DUR_W'(1);
                    end
                end
            end
            ADVANCE: begin
                if (is_last) begin
`ifdef SEQ_LOOP_EN
                    state_d = FETCH;
                    idx_d   = '0;
`else
                    state_d = DONE;
`endif
                end else begin
                    state_d = FETCH;
                    idx_d   = idx_q + 6'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (stop && (state_q != IDLE)) begin
            state_d = IDLE;
        end
        if (state_d == IDLE) begin
            idx_d = '0;
        end
        if (state_d != PLAY) begin
            note_state_d = NOTE_REST;
        end
        if (state_d == DONE) begin
            done_d = 1'b1;
        end
    end

    // Outputs are registered from the next state so they change together with the state itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            idx_q           <= '0;
            len_q           <= '0;
            dur_q           <= '0;
            note_state_q    <= NOTE_REST;
            button_action_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            len_q           <= len_d;
            dur_q           <= dur_d;
            note_state_q    <= note_state_d;
            button_action_q <= (note_state_d != NOTE_REST);
            busy_q          <= (state_d != IDLE);
            done_q          <= done_d;
        end
    end

    assign note_state    = note_state_q;
    assign button_action = button_action_q;
    assign note_idx      = idx_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Self-checking bench for melody_sequencer: per-cycle output stream predicted from the table contents.
// Build with SEQ_LOOP_EN defined to check the looping variant.
module tb_melody_sequencer;

    localparam int TICK_DIV  = 4;
    localparam int GAP_TICKS = 1;
`ifdef SEQ_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    typedef struct {
        logic [5:0] note;
        logic       ba;
        logic       busy;
        logic       done;
        int         idx;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic [6:0]  melody_len;
    logic        prog_we;
    logic [5:0]  prog_addr;
    logic [15:0] prog_data;
    logic [5:0]  note_state;
    logic        button_action;
    logic [5:0]  note_idx;
    logic        busy;
    logic        done;

    logic [15:0] tbl [64];
    exp_t        expQ [$];
    int          checks = 0;
    int          errors = 0;
    int          runNo  = 0;

    melody_sequencer #(
        .TICK_DIV  (TICK_DIV),
        .GAP_TICKS (GAP_TICKS),
        .DEPTH     (64)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .stop          (stop),
        .melody_len    (melody_len),
        .prog_we       (prog_we),
        .prog_addr     (prog_addr),
        .prog_data     (prog_data),
        .note_state    (note_state),
        .button_action (button_action),
        .note_idx      (note_idx),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input exp_t e);
        checks++;
        assert (note_state === e.note) else begin
            errors++;
            $error("FAIL %s note_state observed=%0h expected=%0h", tag, note_state, e.note);
        end
        checks++;
        assert (button_action === e.ba) else begin
            errors++;
            $error("FAIL %s button_action observed=%0b expected=%0b", tag, button_action, e.ba);
        end
        checks++;
        assert (busy === e.busy) else begin
            errors++;
            $error("FAIL %s busy observed=%0b expected=%0b", tag, busy, e.busy);
        end
        checks++;
        assert (done === e.done) else begin
            errors++;
            $error("FAIL %s done observed=%0b expected=%0b", tag, done, e.done);
        end
        if (e.idx >= 0) begin
            checks++;
            assert (note_idx === 6'(e.idx)) else begin
                errors++;
                $error("FAIL %s note_idx observed=%0d expected=%0d", tag, note_idx, e.idx);
            end
        end
    endtask

    task automatic progWrite(input int addr, input logic [15:0] data);
        prog_we   = 1'b1;
        prog_addr = 6'(addr);
        prog_data = data;
        tbl[addr] = data;
        @(posedge clk); #1;
        prog_we   = 1'b0;
    endtask

    // Expected stream, one element per clock starting with the cycle after the start edge:
    // fetch, note for dur ms, gap, advance per entry; zero-duration entries only fetch and advance.
    task automatic buildExpected(input int len);
        exp_t       idle, fetch, play, fin;
        int         passes;
        int         d;
        idle  = '{note: 6'd0, ba: 1'b0, busy: 1'b0, done: 1'b0, idx: -1};
        fetch = '{note: 6'd0, ba: 1'b0, busy: 1'b1, done: 1'b0, idx: -1};
        fin   = '{note: 6'd0, ba: 1'b0, busy: 1'b1, done: 1'b1, idx: -1};
        expQ.delete();
        if (len == 0) begin
            expQ.push_back('{note: 6'd0, ba: 1'b0, busy: 1'b0, done: 1'b1, idx: -1});
            expQ.push_back(idle);
            expQ.push_back(idle);
            return;
        end
        passes = LOOP ? 2 : 1;
        for (int p = 0; p < passes; p++) begin
            for (int i = 0; i < len; i++) begin
                d = int'(tbl[i][9:0]);
                expQ.push_back(fetch);
                if (d != 0) begin
                    play = '{note: tbl[i][15:10], ba: (tbl[i][15:10] != 6'd0),
                             busy: 1'b1, done: 1'b0, idx: i};
                    for (int c = 0; c < d * TICK_DIV; c++) expQ.push_back(play);
                    for (int c = 0; c < GAP_TICKS * TICK_DIV; c++) expQ.push_back(fetch);
                end
                expQ.push_back(fetch);
            end
        end
        if (!LOOP) begin
            expQ.push_back(fin);
            expQ.push_back(idle);
            expQ.push_back(idle);
        end
    endtask

    // Starts playback, checks the stream (optionally truncated by a stop), then stops and checks idle.
    task automatic runSeq(input int len, input int stopAfter, input bit wrSame,
                          input logic [15:0] wrData, input bit wrBusy);
        exp_t idle;
        int   n;
        idle = '{note: 6'd0, ba: 1'b0, busy: 1'b0, done: 1'b0, idx: -1};
        runNo++;
        if (wrSame) begin
            prog_we   = 1'b1;
            prog_addr = 6'd0;
            prog_data = wrData;
            tbl[0]    = wrData;
        end
        buildExpected(len);
        melody_len = 7'(len);
        start      = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        prog_we = 1'b0;
        if (wrBusy) begin
            prog_we   = 1'b1;
            prog_addr = 6'd0;
            prog_data = ~tbl[0];
        end
        n = (stopAfter >= 0 && stopAfter < expQ.size()) ? stopAfter + 1 : expQ.size();
        for (int k = 0; k < n; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            if (k == 3) prog_we = 1'b0;
            checkOutput($sformatf("run%0d cyc%0d", runNo, k), expQ[k]);
        end
        prog_we = 1'b0;
        stop    = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("run%0d afterstop%0d", runNo, k), idle);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        exp_t zero;
        int   len;
        zero       = '{note: 6'd0, ba: 1'b0, busy: 1'b0, done: 1'b0, idx: 0};
        rst        = 1'b1;
        start      = 1'b0;
        stop       = 1'b0;
        melody_len = 7'd0;
        prog_we    = 1'b0;
        prog_addr  = 6'd0;
        prog_data  = 16'd0;
        for (int i = 0; i < 64; i++) tbl[i] = 16'd0;

        #12;
        checkOutput("reset", zero);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] basic three-entry melody");
        progWrite(0, {6'h01, 10'd2});
        progWrite(1, {6'h0C, 10'd1});
        progWrite(2, {6'h00, 10'd1});
        runSeq(3, -1, 1'b0, 16'h0, 1'b0);

        $display("[TB] stop during first note");
        runSeq(3, 4, 1'b0, 16'h0, 1'b0);

        $display("[TB] reset during playback");
        buildExpected(3);
        melody_len = 7'd3;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            checkOutput($sformatf("prereset cyc%0d", k), expQ[k]);
        end
        rst = 1'b1;
        #1;
        checkOutput("reset midplay", zero);
        @(negedge clk);
        rst = 1'b0;
        runSeq(3, -1, 1'b0, 16'h0, 1'b0);

        $display("[TB] zero-duration entry skipped");
        progWrite(1, {6'h0C, 10'd0});
        runSeq(3, -1, 1'b0, 16'h0, 1'b0);

        $display("[TB] zero length start");
        runSeq(0, -1, 1'b0, 16'h0, 1'b0);

        $display("[TB] writes while busy are ignored");
        runSeq(2, -1, 1'b0, 16'h0, 1'b1);
        runSeq(2, -1, 1'b0, 16'h0, 1'b0);

        $display("[TB] write and start in the same cycle");
        runSeq(2, -1, 1'b1, {6'h2A, 10'd1}, 1'b0);

        $display("[TB] randomized tables");
        for (int r = 0; r < 6; r++) begin
            len = int'($urandom_range(1, 8));
            for (int i = 0; i < len; i++) begin
                progWrite(i, {6'($urandom_range(0, 63)), 10'($urandom_range(0, 3))});
            end
            runSeq(len, (r == 5) ? int'($urandom_range(0, 12)) : -1, 1'b0, 16'h0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
